// File: rtl/core101_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : core101_mem_responder
// Brief    : Fixed-latency word-addressed backing memory for the Core101 bus.
// Revision : 1.0 - initial release
// ============================================================================
module core101_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_valid_out,
  output logic              mem_err_out
);

  localparam int        c_DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_is_read;
  logic                  r_both;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_valid;
  logic                  r_err;
  logic [DATA_W-1:0]     r_mem [c_DEPTH];

  logic                  w_req;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oor;
  logic                  w_mis;
  logic                  w_mem_we;

  assign w_req    = mem_read_in | mem_write_in;
  assign w_idx    = r_addr[DEPTH_LOG2+1:2];
  assign w_oor    = |r_addr[ADDR_W-1:DEPTH_LOG2+2];
  assign w_mis    = |r_addr[1:0];
  assign w_mem_we = (r_state == ST_RESP) && !r_is_read && !w_oor;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: w_next = ST_HOLD;
      // Stay here until the core releases the request so it is not served twice.
      ST_HOLD: if (!w_req) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_read <= 1'b0;
      r_both    <= 1'b0;
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr    <= mem_addr_in;
            r_wdata   <= mem_data_in;
            r_is_read <= mem_read_in;
            r_both    <= mem_read_in & mem_write_in;
            r_cnt     <= c_LAT_M1;
          end
        end
        ST_WAIT: r_cnt <= r_cnt - 4'd1;
        ST_RESP: begin
          r_valid <= 1'b1;
          r_err   <= w_oor | w_mis | r_both;
          if (r_is_read) r_rdata <= w_oor ? '0 : r_mem[w_idx];
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock_in) begin
    if (w_mem_we) r_mem[w_idx] <= r_wdata;
  end

  assign mem_data_out  = r_rdata;
  assign mem_valid_out = r_valid;
  assign mem_err_out   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core101_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_core101_mem_responder
// Brief    : Checks LATENCY=1/2/15 responders driven in lockstep against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core101_mem_responder;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rd, wr;
  logic [DW-1:0] dout [3];
  logic          vld  [3];
  logic          err  [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] last_rd;
  logic [DW-1:0] exp_d;
  logic          exp_e;
  int            o_cnt [3], o_first [3], o_stray [3];
  logic [DW-1:0] o_data [3];
  logic          o_err  [3];

  typedef struct {
    bit          r, w;
    logic [31:0] a, d;
    int          hold, window;
  } op_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    core101_mem_responder #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 15))
    ) u_dut (
      .clock_in(clk), .reset_in(rst_n),
      .mem_addr_in(addr), .mem_data_in(wdata),
      .mem_read_in(rd), .mem_write_in(wr),
      .mem_data_out(dout[g]), .mem_valid_out(vld[g]), .mem_err_out(err[g])
    );
  end

  function automatic int lat(int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
  endfunction

  // Drives one transaction from a negedge, records what each DUT returns,
  // and computes the expected response from the memory-map rules.
  task automatic do_txn(input op_t op);
    logic oor, mis;
    int   idx;
    oor = (op.a >> (DL + 2)) != 0;
    mis = (op.a & 32'h3) != 0;
    idx = int'((op.a >> 2) & ((32'h1 << DL) - 1));
    if (op.r) begin
      exp_e   = oor | mis | op.w;
      exp_d   = oor ? 32'h0 : model_mem[idx];
      last_rd = exp_d;
    end else begin
      exp_e = oor | mis;
      if (!oor) model_mem[idx] = op.d;
      exp_d = last_rd;
    end
    for (int i = 0; i < 3; i++) begin
      o_cnt[i] = 0; o_first[i] = -1; o_stray[i] = 0;
      o_data[i] = 'x; o_err[i] = 1'bx;
    end
    rd = op.r; wr = op.w; addr = op.a; wdata = op.d;
    for (int k = 0; k < op.window; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (vld[i] === 1'b1) begin
          if (o_cnt[i] == 0) o_first[i] = k;
          o_cnt[i]++;
          o_data[i] = dout[i];
          o_err[i]  = err[i];
        end else if (err[i] !== 1'b0) begin
          o_stray[i]++;
        end
      end
      if (k == op.hold - 1) begin
        rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; last_rd = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks += 3;
      if (vld[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid lat%0d: got %b want 0", lat(i), vld[i]); end
      if (err[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err lat%0d: got %b want 0", lat(i), err[i]); end
      if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL reset_data lat%0d: got %h want 0", lat(i), dout[i]); end
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_rw;
    op_t ops [$];
    ops = '{'{0, 1, 32'h10, 32'hDEADBEEF, 1, 19}, '{1, 0, 32'h10, 32'h0, 3, 19},
            '{0, 1, 32'h20, 32'h12345678, 1, 19}, '{1, 0, 32'h20, 32'h0, 1, 19}};
    foreach (ops[j]) begin
      do_txn(ops[j]);
      for (int i = 0; i < 3; i++) begin
        n_checks += 3;
        if (o_cnt[i] !== 1 || o_first[i] !== lat(i)) begin n_fail++; $display("FAIL basic%0d_timing lat%0d: %0d pulses first at +%0d, want 1 at +%0d", j, lat(i), o_cnt[i], o_first[i], lat(i)); end
        if (o_data[i] !== exp_d) begin n_fail++; $display("FAIL basic%0d_data lat%0d: got %h want %h", j, lat(i), o_data[i], exp_d); end
        if (o_err[i] !== exp_e || o_stray[i] != 0) begin n_fail++; $display("FAIL basic%0d_err lat%0d: got %b (stray %0d) want %b", j, lat(i), o_err[i], o_stray[i], exp_e); end
      end
    end
  endtask

  task automatic test_held_and_back_to_back;
    op_t ops [$];
    // Held 10 cycles; then held past every latency, dropped for one cycle, re-requested.
    ops = '{'{1, 0, 32'h20, 32'h0, 10, 19}, '{1, 0, 32'h10, 32'h0, 16, 17},
            '{1, 0, 32'h20, 32'h0, 1, 19}};
    foreach (ops[j]) begin
      do_txn(ops[j]);
      for (int i = 0; i < 3; i++) begin
        n_checks += 3;
        if (o_cnt[i] !== 1 || o_first[i] !== lat(i)) begin n_fail++; $display("FAIL held%0d_timing lat%0d: %0d pulses first at +%0d, want 1 at +%0d", j, lat(i), o_cnt[i], o_first[i], lat(i)); end
        if (o_data[i] !== exp_d) begin n_fail++; $display("FAIL held%0d_data lat%0d: got %h want %h", j, lat(i), o_data[i], exp_d); end
        if (o_err[i] !== exp_e || o_stray[i] != 0) begin n_fail++; $display("FAIL held%0d_err lat%0d: got %b (stray %0d) want %b", j, lat(i), o_err[i], o_stray[i], exp_e); end
      end
    end
  endtask

  task automatic test_errors;
    op_t ops [$];
    ops = '{'{0, 1, 32'h0, 32'hCAFEF00D, 1, 19}, '{1, 0, 32'h1000, 32'h0, 1, 19},
            '{1, 0, 32'h3, 32'h0, 1, 19}, '{0, 1, 32'h1000, 32'h11111111, 1, 19},
            '{1, 0, 32'h0, 32'h0, 1, 19}, '{0, 1, 32'h8, 32'h22222222, 1, 19},
            '{1, 1, 32'h8, 32'hBADBAD00, 2, 19}, '{1, 0, 32'h8, 32'h0, 1, 19},
            '{0, 1, 32'h26, 32'h66666666, 1, 19}, '{1, 0, 32'h24, 32'h0, 1, 19}};
    foreach (ops[j]) begin
      do_txn(ops[j]);
      for (int i = 0; i < 3; i++) begin
        n_checks += 3;
        if (o_cnt[i] !== 1 || o_first[i] !== lat(i)) begin n_fail++; $display("FAIL err%0d_timing lat%0d: %0d pulses first at +%0d, want 1 at +%0d", j, lat(i), o_cnt[i], o_first[i], lat(i)); end
        if (o_data[i] !== exp_d) begin n_fail++; $display("FAIL err%0d_data lat%0d: got %h want %h", j, lat(i), o_data[i], exp_d); end
        if (o_err[i] !== exp_e || o_stray[i] != 0) begin n_fail++; $display("FAIL err%0d_err lat%0d: got %b (stray %0d) want %b", j, lat(i), o_err[i], o_stray[i], exp_e); end
      end
    end
  endtask

  task automatic test_reset_mid;
    op_t op;
    int  pulses [3];
    rd = 1'b0; wr = 1'b1; addr = 32'h10; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    #1 rst_n = 1'b0; wr = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks += 2;
      if (vld[i] !== 1'b0 || err[i] !== 1'b0) begin n_fail++; $display("FAIL midrst_flags lat%0d: valid %b err %b want 0 0", lat(i), vld[i], err[i]); end
      if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL midrst_data lat%0d: got %h want 0", lat(i), dout[i]); end
      pulses[i] = 0;
    end
    last_rd = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (18) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (vld[i] !== 1'b0) pulses[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pulses[i] != 0) begin n_fail++; $display("FAIL midrst_novalid lat%0d: got %0d pulses want 0", lat(i), pulses[i]); end
    end
    op = '{1, 0, 32'h10, 32'h0, 1, 19};
    do_txn(op);
    for (int i = 0; i < 3; i++) begin
      n_checks += 3;
      if (o_cnt[i] !== 1 || o_first[i] !== lat(i)) begin n_fail++; $display("FAIL midrst_after_timing lat%0d: %0d pulses first at +%0d, want 1 at +%0d", lat(i), o_cnt[i], o_first[i], lat(i)); end
      if (o_data[i] !== exp_d) begin n_fail++; $display("FAIL midrst_after_data lat%0d: got %h want %h", lat(i), o_data[i], exp_d); end
      if (o_err[i] !== exp_e || o_stray[i] != 0) begin n_fail++; $display("FAIL midrst_after_err lat%0d: got %b (stray %0d) want %b", lat(i), o_err[i], o_stray[i], exp_e); end
    end
  endtask

  task automatic test_random;
    op_t op;
    int  written [$];
    int  sel, idx;
    written = '{0, 2, 4, 8};
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      op.r = (sel >= 4) && (sel != 9 || ($urandom_range(0, 1) == 1));
      op.w = (sel <= 3) || (sel == 8) || (sel == 9 && !op.r);
      if (op.w && !op.r) begin
        idx = $urandom_range(0, (1 << DL) - 1);
        written.push_back(idx);
      end else begin
        idx = written[$urandom_range(0, written.size() - 1)];
      end
      op.a = 32'(idx) << 2;
      if ($urandom_range(0, 3) == 0) op.a = op.a | 32'($urandom_range(1, 3));
      if (sel == 9) op.a = op.a | (32'h1 << $urandom_range(DL + 2, AW - 1));
      op.d = $urandom;
      op.hold = $urandom_range(1, 4);
      op.window = 19;
      do_txn(op);
      for (int i = 0; i < 3; i++) begin
        n_checks += 3;
        if (o_cnt[i] !== 1 || o_first[i] !== lat(i)) begin n_fail++; $display("FAIL rand%0d_timing lat%0d: %0d pulses first at +%0d, want 1 at +%0d", n, lat(i), o_cnt[i], o_first[i], lat(i)); end
        if (o_data[i] !== exp_d) begin n_fail++; $display("FAIL rand%0d_data lat%0d addr %h: got %h want %h", n, lat(i), op.a, o_data[i], exp_d); end
        if (o_err[i] !== exp_e || o_stray[i] != 0) begin n_fail++; $display("FAIL rand%0d_err lat%0d addr %h: got %b (stray %0d) want %b", n, lat(i), op.a, o_err[i], o_stray[i], exp_e); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_rw;
    test_held_and_back_to_back;
    test_errors;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
